// File: rtl/ps2_key_decoder_if.sv
// Byte path between the keyboard receiver and the decoder, plus the
// show-ahead character port toward the consumer.
interface ps2_key_decoder_if;
   logic [7:0] kb_data;
   logic       kb_ready;
   logic       kb_nextdata_n;
   logic       rd_en;
   logic [7:0] out_data;
   logic       out_valid;

   // master: the keyboard receiver and the character consumer side
   modport master (output kb_data, kb_ready, rd_en,
                   input  kb_nextdata_n, out_data, out_valid);
   // slave: the decoder itself
   modport slave  (input  kb_data, kb_ready, rd_en,
                   output kb_nextdata_n, out_data, out_valid);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scancode to ASCII decoder with modifier tracking, optional
// typematic-repeat suppression and a show-ahead character FIFO.
module ps2_key_decoder #(
   parameter int FIFO_DEPTH = 8,
   parameter int REPEAT_EN  = 1,
   parameter int CTRL_EN    = 1
) (
   input  logic                          clk,
   input  logic                          clrn,
   ps2_key_decoder_if.slave              bus,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          caps_lock,
   output logic                          shift_held
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

   typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} state_t;
   state_t state, state_nxt;

   logic [7:0]    byte_q;
   logic [1:0]    busy;
   logic          nack;
   logic          shift_l, shift_r, ctrl, caps_held;
   logic          last_vld, last_ext;
   logic [7:0]    last_code;
   logic          ev_make, ev_brk, ev_ext;
   logic          byte_vld;
   logic          is_shl, is_shr, is_ctrl, is_caps, is_mod, rep;
   logic [8:0]    lt;
   logic [16:0]   sy;
   logic [7:0]    ch;
   logic          ch_hit, push, pop, full, wr, drop;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   // {hit, lower-case ascii} for letter keys
   function automatic logic [8:0] letter_lc(input logic [7:0] c);
      case (c)
         8'h1C: return {1'b1, 8'h61};  8'h32: return {1'b1, 8'h62};
         8'h21: return {1'b1, 8'h63};  8'h23: return {1'b1, 8'h64};
         8'h24: return {1'b1, 8'h65};  8'h2B: return {1'b1, 8'h66};
         8'h34: return {1'b1, 8'h67};  8'h33: return {1'b1, 8'h68};
         8'h43: return {1'b1, 8'h69};  8'h3B: return {1'b1, 8'h6A};
         8'h42: return {1'b1, 8'h6B};  8'h4B: return {1'b1, 8'h6C};
         8'h3A: return {1'b1, 8'h6D};  8'h31: return {1'b1, 8'h6E};
         8'h44: return {1'b1, 8'h6F};  8'h4D: return {1'b1, 8'h70};
         8'h15: return {1'b1, 8'h71};  8'h2D: return {1'b1, 8'h72};
         8'h1B: return {1'b1, 8'h73};  8'h2C: return {1'b1, 8'h74};
         8'h3C: return {1'b1, 8'h75};  8'h2A: return {1'b1, 8'h76};
         8'h1D: return {1'b1, 8'h77};  8'h22: return {1'b1, 8'h78};
         8'h35: return {1'b1, 8'h79};  8'h1A: return {1'b1, 8'h7A};
         default: return 9'h000;
      endcase
   endfunction

   // {hit, unshifted, shifted} for digits, punctuation and control keys
   function automatic logic [16:0] sym_lut(input logic [7:0] c);
      case (c)
         8'h45: return {1'b1, 8'h30, 8'h29};  8'h16: return {1'b1, 8'h31, 8'h21};
         8'h1E: return {1'b1, 8'h32, 8'h40};  8'h26: return {1'b1, 8'h33, 8'h23};
         8'h25: return {1'b1, 8'h34, 8'h24};  8'h2E: return {1'b1, 8'h35, 8'h25};
         8'h36: return {1'b1, 8'h36, 8'h5E};  8'h3D: return {1'b1, 8'h37, 8'h26};
         8'h3E: return {1'b1, 8'h38, 8'h2A};  8'h46: return {1'b1, 8'h39, 8'h28};
         8'h0E: return {1'b1, 8'h60, 8'h7E};  8'h4E: return {1'b1, 8'h2D, 8'h5F};
         8'h55: return {1'b1, 8'h3D, 8'h2B};  8'h54: return {1'b1, 8'h5B, 8'h7B};
         8'h5B: return {1'b1, 8'h5D, 8'h7D};  8'h5D: return {1'b1, 8'h5C, 8'h7C};
         8'h4C: return {1'b1, 8'h3B, 8'h3A};  8'h52: return {1'b1, 8'h27, 8'h22};
         8'h41: return {1'b1, 8'h2C, 8'h3C};  8'h49: return {1'b1, 8'h2E, 8'h3E};
         8'h4A: return {1'b1, 8'h2F, 8'h3F};  8'h29: return {1'b1, 8'h20, 8'h20};
         8'h5A: return {1'b1, 8'h0D, 8'h0D};  8'h66: return {1'b1, 8'h08, 8'h08};
         8'h0D: return {1'b1, 8'h09, 8'h09};  8'h76: return {1'b1, 8'h1B, 8'h1B};
         default: return 17'h00000;
      endcase
   endfunction

   // busy==2 marks the single cycle in which the latched byte is decoded
   assign byte_vld          = (busy == 2'd2);
   assign bus.kb_nextdata_n = nack;
   assign shift_held        = shift_l | shift_r;

   // byte capture and ack pulse; the two busy cycles give the receiver
   // time to drop kb_ready after seeing the ack
   always_ff @(posedge clk) begin
      if (!clrn) begin
         byte_q <= 8'h00;
         busy   <= 2'd0;
         nack   <= 1'b1;
      end else begin
         nack <= 1'b1;
         if (busy != 2'd0) begin
            busy <= busy - 2'd1;
         end else if (bus.kb_ready) begin
            byte_q <= bus.kb_data;
            busy   <= 2'd2;
            nack   <= 1'b0;
         end
      end
   end

   // prefix state register
   always_ff @(posedge clk) begin
      if (!clrn) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // prefix sequencing: classify each byte as make/break, normal/extended
   always_comb begin
      state_nxt = state;
      ev_make   = 1'b0;
      ev_brk    = 1'b0;
      ev_ext    = 1'b0;
      if (byte_vld) begin
         if (byte_q == 8'hE0) begin
            state_nxt = S_EXT;
         end else begin
            case (state)
               S_IDLE:   if (byte_q == 8'hF0) state_nxt = S_BRK;
                         else ev_make = 1'b1;
               S_BRK:    begin ev_brk = 1'b1; state_nxt = S_IDLE; end
               S_EXT:    if (byte_q == 8'hF0) state_nxt = S_EXTBRK;
                         else begin ev_make = 1'b1; ev_ext = 1'b1; state_nxt = S_IDLE; end
               default:  begin ev_brk = 1'b1; ev_ext = 1'b1; state_nxt = S_IDLE; end
            endcase
         end
      end
   end

   assign is_shl  = ~ev_ext & (byte_q == 8'h12);
   assign is_shr  = ~ev_ext & (byte_q == 8'h59);
   assign is_caps = ~ev_ext & (byte_q == 8'h58);
   assign is_ctrl = (byte_q == 8'h14);
   assign is_mod  = is_shl | is_shr | is_caps | is_ctrl;
   assign rep     = last_vld & (last_code == byte_q) & (last_ext == ev_ext);

   // translate the current make code to ASCII under present modifiers
   always_comb begin
      lt     = letter_lc(byte_q);
      sy     = sym_lut(byte_q);
      ch     = 8'h00;
      ch_hit = 1'b0;
      if (ev_ext) begin
         if (byte_q == 8'h4A)      begin ch = 8'h2F; ch_hit = 1'b1; end
         else if (byte_q == 8'h5A) begin ch = 8'h0D; ch_hit = 1'b1; end
      end else if (lt[8]) begin
         ch_hit = 1'b1;
         if ((CTRL_EN != 0) && ctrl)       ch = lt[7:0] - 8'h60;
         else if (shift_held ^ caps_lock)  ch = lt[7:0] - 8'h20;
         else                              ch = lt[7:0];
      end else if (sy[16]) begin
         ch_hit = 1'b1;
         ch     = shift_held ? sy[7:0] : sy[15:8];
      end
   end

   assign push = ev_make & ~is_mod & ch_hit & ~((REPEAT_EN == 0) & rep);

   // modifier flags and last-key tracking
   always_ff @(posedge clk) begin
      if (!clrn) begin
         shift_l   <= 1'b0;
         shift_r   <= 1'b0;
         ctrl      <= 1'b0;
         caps_held <= 1'b0;
         caps_lock <= 1'b0;
         last_vld  <= 1'b0;
         last_ext  <= 1'b0;
         last_code <= 8'h00;
      end else if (ev_make) begin
         if (is_shl)  shift_l <= 1'b1;
         if (is_shr)  shift_r <= 1'b1;
         if (is_ctrl) ctrl    <= 1'b1;
         if (is_caps) begin
            caps_held <= 1'b1;
            if (!caps_held) caps_lock <= ~caps_lock;
         end
         if (!is_mod) begin
            last_vld  <= 1'b1;
            last_ext  <= ev_ext;
            last_code <= byte_q;
         end
      end else if (ev_brk) begin
         if (is_shl)  shift_l   <= 1'b0;
         if (is_shr)  shift_r   <= 1'b0;
         if (is_ctrl) ctrl      <= 1'b0;
         if (is_caps) caps_held <= 1'b0;
         if (!is_mod && rep) last_vld <= 1'b0;
      end
   end

   assign full = (count == DEPTH_C);
   assign pop  = bus.rd_en & (count != '0);
   assign wr   = push & (~full | pop);
   assign drop = push & full & ~pop;

   // character storage, no reset needed
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= ch;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk) begin
      if (!clrn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

   assign fifo_count    = count;
   assign bus.out_valid = (count != '0);
   assign bus.out_data  = (count != '0) ? mem[rd_ptr] : 8'h00;
endmodule
